putb_rmw: RTL and testbench

- Byte-store engine: writes one 8-bit value into a selected byte lane of a 32-bit word in word-addressed memory.
- Performs a read-modify-write: read the word, replace lane `byte_idx` with `din`, write the word back.
- Sits between the CPU store path and the word-only memory bus.
- Lane numbering is little-endian: lane 0 = bits 7:0 … lane 3 = bits 31:24.

---
 rtl/putb_rmw.sv | 137 +++++++++++++
 tb/tb_putb_rmw.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/putb_rmw.sv
// Byte-store read-modify-write engine: reads a word, replaces one byte lane, writes it back.
// Define PUTB_TIMEOUT_EN to abort a bus phase after TIMEOUT cycles without mem_ack.
module putb_rmw #(
    parameter int AW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] addr,
    input  logic [1:0]    byte_idx,
    input  logic [7:0]    din,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [31:0]   word_out,
    output logic [AW-1:0] mem_addr,
    output logic          mem_req,
    output logic          mem_wr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ack
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t      state;
    logic [1:0]  idx_q;
    logic [7:0]  din_q;
    logic [31:0] merged;
    logic        timed_out;

    if (TIMEOUT < 1) begin : g_timeout_chk
        $error("putb_rmw: TIMEOUT must be >= 1");
    end

    always_comb begin
        merged = mem_rdata;
        case (idx_q)
            2'd0:    merged[7:0]   = din_q;
            2'd1:    merged[15:8]  = din_q;
            2'd2:    merged[23:16] = din_q;
            default: merged[31:24] = din_q;
        endcase
    end

    // Write data is always the last merged word.
    assign mem_wdata = word_out;

`ifdef PUTB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CW-1:0] wait_cnt;

    // Cleared while idle and on the RD->WR hand-off, so each phase gets a full budget.
    always_ff @(posedge clk) begin
        if (reset || state == IDLE || (state == RD && mem_ack))
            wait_cnt <= '0;
        else if (!mem_ack)
            wait_cnt <= wait_cnt + 1'b1;
    end

    assign timed_out = !mem_ack && (wait_cnt == CW'(TIMEOUT - 1));
`else
    assign timed_out = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            mem_req  <= 1'b0;
            mem_wr   <= 1'b0;
            mem_addr <= '0;
            word_out <= '0;
            idx_q    <= '0;
            din_q    <= '0;
`ifdef PUTB_TIMEOUT_EN
            err      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef PUTB_TIMEOUT_EN
            err  <= 1'b0;
`endif
            case (state)
                IDLE: if (start) begin
                    mem_addr <= addr;
                    idx_q    <= byte_idx;
                    din_q    <= din;
                    state    <= RD;
                    busy     <= 1'b1;
                    mem_req  <= 1'b1;
                    mem_wr   <= 1'b0;
                end
                RD: if (mem_ack) begin
                    word_out <= merged;
                    state    <= WR;
                    mem_wr   <= 1'b1;
                end else if (timed_out) begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    mem_req  <= 1'b0;
`ifdef PUTB_TIMEOUT_EN
                    err      <= 1'b1;
`endif
                end
                WR: if (mem_ack) begin
                    state    <= DONE;
                    mem_req  <= 1'b0;
                    mem_wr   <= 1'b0;
                    done     <= 1'b1;
                end else if (timed_out) begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    mem_req  <= 1'b0;
                    mem_wr   <= 1'b0;
`ifdef PUTB_TIMEOUT_EN
                    err      <= 1'b1;
`endif
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    mem_req <= 1'b0;
                    mem_wr  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_putb_rmw.sv
// Scoreboard bench for putb_rmw: expected writes are queued by stimulus, checked by a bus monitor.
module tb_putb_rmw;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [15:0] addr;
    logic [1:0]  byte_idx;
    logic [7:0]  din;
    logic        busy, done, err, mem_req, mem_wr, mem_ack;
    logic [31:0] word_out, mem_wdata, mem_rdata;
    logic [15:0] mem_addr;

    putb_rmw #(.AW(16), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .start(start), .addr(addr), .byte_idx(byte_idx), .din(din),
        .busy(busy), .done(done), .err(err), .word_out(word_out), .mem_addr(mem_addr),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;
    int wr_cnt = 0, done_cnt = 0, err_cnt = 0;

    typedef struct packed { logic [15:0] a; logic [31:0] d; } wr_t;
    wr_t exp_q[$];
    int  wr_cyc[$];

    // Memory model: ack after a per-phase number of wait cycles.
    logic [31:0] rdata_v = '0;
    bit          ack_en = 1'b1;
    int          rd_dly = 0, wr_dly = 0, wcnt = 0;
    assign mem_rdata = rdata_v;
    assign mem_ack   = ack_en && mem_req && (wcnt >= (mem_wr ? wr_dly : rd_dly));
    always @(posedge clk) begin
        if (reset || !mem_req || mem_ack) wcnt <= 0;
        else                              wcnt <= wcnt + 1;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Monitor: a write completes in any cycle with req, wr and ack all high.
    initial forever begin
        wr_t e;
        @(negedge clk);
        if (done) done_cnt++;
        if (err)  err_cnt++;
        if (mem_req && mem_wr && mem_ack) begin
            wr_cnt++;
            wr_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {mem_addr, 16'h0}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", {16'h0, mem_addr}, {16'h0, e.a});
                chk("write_data", mem_wdata, e.d);
            end
        end
    end

    task automatic issue(input logic [15:0] a, input logic [1:0] idx, input logic [7:0] d,
                         output int ts);
        start = 1'b1; addr = a; byte_idx = idx; din = d;
        ts = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int ts, input int lat, input string nm);
        int t = -1;
        for (int i = 0; i < 40; i++) begin
            if (done) begin t = cyc; break; end
            @(negedge clk);
        end
        chk({nm, "_done_cycle"}, 32'(t), 32'(ts + lat));
        @(negedge clk);
        chk({nm, "_busy_after"}, {31'h0, busy}, 32'h0);
    endtask

    logic [31:0] lane_exp [4] = '{32'hFFFFFF00, 32'hFFFF00FF, 32'hFF00FFFF, 32'h00FFFFFF};

    initial begin
        int ts, ts2, t, drops, w0, d0, e0, bad_busy, bad_err;
        reset = 1'b1; start = 1'b0; addr = '0; byte_idx = '0; din = '0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {27'h0, busy, done, err, mem_req, mem_wr}, 32'h0);
        chk("rst_word_out", word_out, 32'h0);
        chk("rst_addr_wdata", {16'h0, mem_addr} | mem_wdata, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Zero-wait store
        rdata_v = 32'h11223344;
        exp_q.push_back('{16'h0010, 32'h11A53344});
        issue(16'h0010, 2'd2, 8'hA5, ts);
        chk("rd_phase", {15'h0, mem_req, mem_wr, mem_addr}, {15'h0, 1'b1, 1'b0, 16'h0010});
        wait_done(ts, 3, "zero_wait");
        chk("zero_wait_word_out", word_out, 32'h11A53344);

        // Every lane
        rdata_v = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{16'h0100 + 16'(i), lane_exp[i]});
            issue(16'h0100 + 16'(i), 2'(i), 8'h00, ts);
            wait_done(ts, 3, "lane");
            chk("lane_word_out", word_out, lane_exp[i]);
        end

        // Wait states, operand changes and a stray start mid-op
        rdata_v = 32'hDEADBEEF; rd_dly = 3; wr_dly = 2;
        w0 = wr_cnt; drops = 0; t = -1;
        exp_q.push_back('{16'h0020, 32'hDEAD5AEF});
        issue(16'h0020, 2'd1, 8'h5A, ts);
        for (int i = 0; i < 30; i++) begin
            if (done) begin t = cyc; break; end
            if (!mem_req) drops++;
            addr = 16'hFFFF; din = 8'h00; byte_idx = 2'd3;
            start = mem_wr;
            @(negedge clk);
        end
        start = 1'b0;
        chk("wait_done_cycle", 32'(t), 32'(ts + 8));
        chk("wait_req_held", 32'(drops), 32'h0);
        repeat (4) @(negedge clk);
        chk("wait_single_write", 32'(wr_cnt - w0), 32'h1);
        chk("wait_idle_after", {31'h0, busy}, 32'h0);
        rd_dly = 0; wr_dly = 0;

        // Back-to-back stores
        rdata_v = 32'h0;
        exp_q.push_back('{16'h0030, 32'h00000077});
        exp_q.push_back('{16'h0031, 32'h00008800});
        issue(16'h0030, 2'd0, 8'h77, ts);
        wait_done(ts, 3, "b2b_first");
        issue(16'h0031, 2'd1, 8'h88, ts2);
        chk("b2b_start_cycle", 32'(ts2), 32'(ts + 4));
        chk("b2b_second_rd", {30'h0, mem_req, mem_wr}, 32'h2);
        wait_done(ts2, 3, "b2b_second");
        chk("b2b_write_spacing", 32'(wr_cyc[$] - wr_cyc[$-1]), 32'h4);

        // Reset held two cycles during WR
        wr_dly = 100;
        issue(16'h0040, 2'd3, 8'h12, ts);
        for (int i = 0; i < 10 && !mem_wr; i++) @(negedge clk);
        chk("rstwr_in_wr", {31'h0, mem_wr}, 32'h1);
        d0 = done_cnt;
        reset = 1'b1;
        @(negedge clk);
        chk("rstwr_ctrl", {29'h0, mem_req, mem_wr, busy}, 32'h0);
        chk("rstwr_word_out", word_out, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rstwr_no_done", 32'(done_cnt - d0), 32'h0);
        chk("rstwr_idle", {31'h0, busy}, 32'h0);
        wr_dly = 0;

        // Memory never acknowledges the read
        ack_en = 1'b0;
        w0 = wr_cnt; e0 = err_cnt; d0 = done_cnt;
        issue(16'h0050, 2'd0, 8'h99, ts);
`ifdef PUTB_TIMEOUT_EN
        for (int i = 0; i < 60 && busy; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        chk("to_err_once", 32'(err_cnt - e0), 32'h1);
        chk("to_idle", {31'h0, busy}, 32'h0);
        chk("to_no_write", 32'(wr_cnt - w0), 32'h0);
        chk("to_no_done", 32'(done_cnt - d0), 32'h0);
`else
        bad_busy = 0; bad_err = 0;
        for (int i = 0; i < 100; i++) begin
            if (!busy) bad_busy++;
            if (err)   bad_err++;
            @(negedge clk);
        end
        chk("hang_busy_held", 32'(bad_busy), 32'h0);
        chk("hang_err_zero", 32'(bad_err), 32'h0);
        chk("hang_no_write", 32'(wr_cnt - w0), 32'h0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
`endif
        ack_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
